// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register and req/ready fetch stage feeding the control unit.
// Fetches one word per REQ/ISSUE round trip; a timeout or misaligned target parks it in FAULT.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MAX_WAIT  = 16,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic [31:0] i_imem_rdata,
    output logic        o_instr_valid,
    input  logic        i_instr_ack,
    output logic [31:0] o_instr,
    output logic [6:0]  o_op,
    output logic [2:0]  o_func3,
    output logic        o_func7,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    input  logic        i_pc_src,
    input  logic [31:0] i_pc_target,
    output logic        o_fetch_fault
);
    localparam int WW = $clog2(MAX_WAIT);
    typedef enum logic [1:0] {S_REQ, S_ISSUE, S_FAULT} state_t;
    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_fault;
    logic [WW-1:0] r_wait;
    logic        w_timeout;
    logic        w_misaligned;
    assign w_timeout     = r_wait == WW'(MAX_WAIT - 1);
    assign w_misaligned  = i_pc_target[1:0] != 2'b00;
    // Gated by reset so the request stays low until reset is released.
    assign o_imem_req    = r_state == S_REQ && !i_reset;
    assign o_imem_addr   = r_pc;
    assign o_instr_valid = r_state == S_ISSUE;
    assign o_instr       = r_instr;
    assign o_op          = r_instr[6:0];
    assign o_func3       = r_instr[14:12];
    assign o_func7       = r_instr[30];
    assign o_pc          = r_pc;
    assign o_pc_plus4    = r_pc + 32'd4;
    assign o_fetch_fault = r_fault;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_fault <= 1'b0;
            r_wait  <= '0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (i_imem_ready) begin
                        r_instr <= i_imem_rdata;
                        r_wait  <= '0;
                        r_state <= S_ISSUE;
                    end else if (w_timeout) begin
                        r_fault <= 1'b1;
                        r_instr <= NOP_INSTR;
                        r_state <= S_FAULT;
                    end else begin
                        r_wait <= r_wait + WW'(1);
                    end
                end
                S_ISSUE: begin
                    if (i_instr_ack) begin
                        if (!i_pc_src) begin
                            r_pc    <= r_pc + 32'd4;
                            r_state <= S_REQ;
                        end else if (!w_misaligned) begin
                            r_pc    <= i_pc_target;
                            r_state <= S_REQ;
                        end else begin
                            r_fault <= 1'b1;
                            r_instr <= NOP_INSTR;
                            r_state <= S_FAULT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios plus randomized traffic checked every cycle
// against a transaction-level model of the fetch stage.
module tb_instr_fetch_unit;
    localparam int MAX_WAIT = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 0;
    logic        rst = 0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 0;
    logic [31:0] imem_rdata = 0;
    logic        instr_valid;
    logic        instr_ack = 0;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  func3;
    logic        func7;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_src = 0;
    logic [31:0] pc_target = 0;
    logic        fetch_fault;

    int checks = 0;
    int failures = 0;
    bit en = 0;

    logic [31:0] m_pc = 0;
    logic [31:0] m_instr = NOP;
    bit          m_have = 0;
    bit          m_fault = 0;
    int          m_miss = 0;

    instr_fetch_unit #(.RESET_PC(32'h0), .MAX_WAIT(MAX_WAIT), .NOP_INSTR(NOP)) dut (
        .i_clk(clk), .i_reset(rst),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr),
        .i_imem_ready(imem_ready), .i_imem_rdata(imem_rdata),
        .o_instr_valid(instr_valid), .i_instr_ack(instr_ack),
        .o_instr(instr), .o_op(op), .o_func3(func3), .o_func7(func7),
        .o_pc(pc), .o_pc_plus4(pc_plus4),
        .i_pc_src(pc_src), .i_pc_target(pc_target),
        .o_fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference model: "have" = an instruction is being presented, "miss" = consecutive unanswered requests.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_pc = 0; m_instr = NOP; m_have = 0; m_fault = 0; m_miss = 0;
        end else if (m_fault) begin
        end else if (!m_have) begin
            if (imem_ready) begin
                m_instr = imem_rdata; m_have = 1; m_miss = 0;
            end else begin
                m_miss = m_miss + 1;
                if (m_miss == MAX_WAIT) begin m_fault = 1; m_instr = NOP; end
            end
        end else if (instr_ack) begin
            m_have = 0;
            if (!pc_src) m_pc = m_pc + 4;
            else if (pc_target % 4 == 0) m_pc = pc_target;
            else begin m_fault = 1; m_instr = NOP; end
        end
    end

    initial forever begin
        @(negedge clk);
        if (en) begin
            chk("req", {31'b0, imem_req}, {31'b0, !m_fault && !m_have && !rst});
            chk("valid", {31'b0, instr_valid}, {31'b0, m_have && !m_fault});
            chk("addr", imem_addr, m_pc);
            chk("pc", pc, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("instr", instr, m_instr);
            chk("op", {25'b0, op}, {25'b0, m_instr[6:0]});
            chk("func3", {29'b0, func3}, {29'b0, m_instr[14:12]});
            chk("func7", {31'b0, func7}, {31'b0, m_instr[30]});
            chk("fault", {31'b0, fetch_fault}, {31'b0, m_fault});
        end
    end

    initial begin
        logic [31:0] t;
        int mode;
        #1 rst = 1;
        tick(); tick();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h13);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
        en = 1;
        // sequential fetch 0,4,8,C
        rst = 0; imem_ready = 1; instr_ack = 1; pc_src = 0; imem_rdata = NOP;
        #1;
        chk("t1_addr0", imem_addr, 32'h0);
        chk("t1_req0", {31'b0, imem_req}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("t1_valid", {31'b0, instr_valid}, 32'd1);
            chk("t1_pc", pc, 32'(4 * (k - 1)));
            tick();
            chk("t1_addr", imem_addr, 32'(4 * k));
        end
        // beq decode and taken branch
        imem_rdata = 32'h00B5_0463; instr_ack = 0;
        tick();
        chk("t2_op", {25'b0, op}, 32'h63);
        chk("t2_func3", {29'b0, func3}, 32'd0);
        chk("t2_func7", {31'b0, func7}, 32'd0);
        instr_ack = 1; pc_src = 1; pc_target = 32'h40;
        tick();
        chk("t2_target", imem_addr, 32'h40);
        // 15-cycle stall survives, 16-cycle stall faults
        instr_ack = 0; pc_src = 0; imem_ready = 0;
        repeat (15) tick();
        chk("t3_nofault", {31'b0, fetch_fault}, 32'd0);
        imem_ready = 1; imem_rdata = 32'h4000_5033;
        tick();
        chk("t3_valid", {31'b0, instr_valid}, 32'd1);
        chk("t3_func7", {31'b0, func7}, 32'd1);
        chk("t3_func3", {29'b0, func3}, 32'd5);
        instr_ack = 1; imem_ready = 0;
        tick();
        instr_ack = 0;
        repeat (16) tick();
        chk("t3_fault", {31'b0, fetch_fault}, 32'd1);
        chk("t3_nop", instr, 32'h13);
        chk("t3_pc", pc, 32'h44);
        chk("t3_req", {31'b0, imem_req}, 32'd0);
        // misaligned branch target
        rst = 1; tick();
        rst = 0; imem_ready = 1; instr_ack = 1; pc_src = 0; imem_rdata = 32'h0000_0063;
        tick(); tick(); tick();
        pc_src = 1; pc_target = 32'h42;
        tick();
        chk("t4_fault", {31'b0, fetch_fault}, 32'd1);
        chk("t4_pc", pc, 32'h4);
        tick(); tick();
        chk("t4_req", {31'b0, imem_req}, 32'd0);
        // hold in ISSUE without ack
        rst = 1; tick();
        rst = 0; imem_ready = 1; instr_ack = 0; pc_src = 0; imem_rdata = 32'hDEAD_B0B3;
        tick();
        for (int k = 0; k < 5; k++) begin
            pc_src = k[0]; pc_target = $urandom; imem_ready = $urandom_range(0, 1) == 1; imem_rdata = $urandom;
            tick();
            chk("t5_instr", instr, 32'hDEAD_B0B3);
            chk("t5_pc", pc, 32'h0);
            chk("t5_req", {31'b0, imem_req}, 32'd0);
        end
        // PC wrap
        imem_ready = 1; instr_ack = 1; pc_src = 1; pc_target = 32'hFFFF_FFFC;
        tick();
        chk("t6_hi", imem_addr, 32'hFFFF_FFFC);
        instr_ack = 0; pc_src = 0;
        tick();
        chk("t6_plus4", pc_plus4, 32'h0);
        instr_ack = 1;
        tick();
        chk("t6_wrap", imem_addr, 32'h0);
        chk("t6_nofault", {31'b0, fetch_fault}, 32'd0);
        tick(); tick();
        // asynchronous reset in the middle of a REQ cycle
        #2 rst = 1;
        #1;
        chk("t6_rst_pc", pc, 32'h0);
        chk("t6_rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("t6_rst_instr", instr, 32'h13);
        tick();
        rst = 0;
        // randomized traffic
        mode = 1;
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) mode = $urandom_range(0, 3);
            rst = $urandom_range(0, 149) == 0;
            imem_ready = mode == 0 ? 1'b0 : $urandom_range(0, 3) != 0;
            imem_rdata = $urandom;
            instr_ack = $urandom_range(0, 2) != 0;
            pc_src = $urandom_range(0, 3) == 0;
            t = $urandom;
            if ($urandom_range(0, 15) != 0) t[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) t[31:4] = 28'hFFFF_FFF;
            pc_target = t;
            tick();
        end
        rst = 0;
        tick(); tick();
        en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
